window_stream_gen: RTL and testbench

// - Generic sliding-window generator: successor of the fixed-kernel SRAM + line-buffer front end.
// - Takes a row-major pixel stream (NFMAPS channels/beat), emits a full KER_SIZE x KER_SIZE window
//   per channel per output position.
// - Any KER_SIZE, 2-D stride and zero pad; valid/ready on both sides with full backpressure.
// - Sits between the activation fetch and the MAC array.

---
 rtl/window_stream_gen.sv | 211 +++++++++++++++++++++
 tb/tb_window_stream_gen.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_stream_gen.sv
// ---------------------------------------------------------------------------
// window_stream_gen
//   Generic sliding-window generator. It consumes a row-major pixel stream
//   (NFMAPS channels per beat) and emits one KER_SIZE x KER_SIZE window per
//   channel for every output position. It supports zero padding on all four
//   sides, a common x/y stride, and valid/ready backpressure on both ports.
//
// Ports
//   clk        clock
//   rstn       asynchronous active-low reset
//   clear      synchronous abort: FSM back to IDLE, counters to 0, slot dropped
//   in_valid   in_data is valid
//   in_ready   block takes in_data this cycle (combinational, no in_valid path)
//   in_data    channel c at [c*BITWIDTH +: BITWIDTH]
//   out_valid  out_win is valid
//   out_ready  sink accepts out_win
//   out_win    ch c, row r (0=top), col k (0=left) at
//              [(c*K*K + r*K + k)*BITWIDTH +: BITWIDTH]
//   frame_done one-cycle pulse after the last window of a frame is accepted
// ---------------------------------------------------------------------------
module window_stream_gen #(
  parameter int KER_SIZE = 3,
  parameter int BITWIDTH = 8,
  parameter int NFMAPS   = 3,
  parameter int IMG_W    = 32,
  parameter int IMG_H    = 32,
  parameter int STRIDE   = 1,
  parameter int PAD      = 1
) (
  input  logic                                          clk,
  input  logic                                          rstn,
  input  logic                                          clear,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [NFMAPS*BITWIDTH-1:0]                    in_data,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [NFMAPS*KER_SIZE*KER_SIZE*BITWIDTH-1:0]  out_win,
  output logic                                          frame_done
);

  localparam int PW   = IMG_W + 2 * PAD;
  localparam int PH   = IMG_H + 2 * PAD;
  localparam int XW   = $clog2(PW + 1);
  localparam int YW   = $clog2(PH + 1);
  localparam int AW   = (PW > 1) ? $clog2(PW) : 1;
  localparam int SW   = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam int PIXW = NFMAPS * BITWIDTH;
  localparam int WINW = NFMAPS * KER_SIZE * KER_SIZE * BITWIDTH;
  localparam int KK   = KER_SIZE * KER_SIZE;

  localparam logic [XW-1:0] X_LAST   = XW'(PW - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(PH - 1);
  localparam logic [XW-1:0] X_IN_LO  = XW'(PAD);
  localparam logic [XW-1:0] X_IN_HI  = XW'(IMG_W + PAD);
  localparam logic [YW-1:0] Y_IN_LO  = YW'(PAD);
  localparam logic [YW-1:0] Y_IN_HI  = YW'(IMG_H + PAD);
  localparam logic [XW-1:0] X_KM1    = XW'(KER_SIZE - 1);
  localparam logic [YW-1:0] Y_KM1    = YW'(KER_SIZE - 1);
  localparam logic [SW-1:0] S_LAST   = SW'(STRIDE - 1);
  localparam logic          HAS_PAD  = (PAD > 0);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t            state_q, state_d;
  logic [XW-1:0]     px_q, px_d;
  logic [YW-1:0]     py_q, py_d;
  logic [SW-1:0]     sx_q, sx_d;         // x phase within stride, 0 = emitting column
  logic [SW-1:0]     sy_q, sy_d;         // y phase within stride, 0 = emitting row
  logic              out_valid_q, out_valid_d;
  logic [WINW-1:0]   out_win_q, out_win_d;
  logic              frame_done_q, frame_done_d;

  // Line memories: lm_q[0] holds row py-K+1, lm_q[K-2] holds row py-1.
  logic [PIXW-1:0]   lm_q  [KER_SIZE-1][PW];
  logic [PIXW-1:0]   win_q [KER_SIZE][KER_SIZE];
  logic [PIXW-1:0]   win_d [KER_SIZE][KER_SIZE];

  logic              interior, emit_pos, slot_free, step;
  logic [PIXW-1:0]   pix_in;
  logic [PIXW-1:0]   new_col [KER_SIZE];
  logic [WINW-1:0]   win_flat;

  // Datapath: scan-position decode, column assembly and window shift.
  // NOTE: every signal written in an always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    interior  = (px_q >= X_IN_LO) && (px_q < X_IN_HI) &&
                (py_q >= Y_IN_LO) && (py_q < Y_IN_HI);
    emit_pos  = (px_q >= X_KM1) && (py_q >= Y_KM1) && (sx_q == '0) && (sy_q == '0);
    // The output slot blocks only steps that would overwrite a pending window.
    slot_free = !emit_pos || !out_valid_q || out_ready;
    in_ready  = (state_q == S_RUN) && interior && slot_free;
    step      = (state_q == S_RUN) && (interior ? in_valid : 1'b1) && slot_free;
    pix_in    = interior ? in_data : '0;

    for (int r = 0; r < KER_SIZE - 1; r++) new_col[r] = lm_q[r][px_q[AW-1:0]];
    new_col[KER_SIZE-1] = pix_in;

    win_d = win_q;
    if (step) begin
      for (int r = 0; r < KER_SIZE; r++) begin
        for (int k = 0; k < KER_SIZE - 1; k++) win_d[r][k] = win_q[r][k+1];
        win_d[r][KER_SIZE-1] = new_col[r];
      end
    end

    win_flat = '0;
    for (int c = 0; c < NFMAPS; c++)
      for (int r = 0; r < KER_SIZE; r++)
        for (int k = 0; k < KER_SIZE; k++)
          win_flat[(c*KK + r*KER_SIZE + k)*BITWIDTH +: BITWIDTH] =
            win_d[r][k][c*BITWIDTH +: BITWIDTH];
  end

  // Control: FSM, scan counters, output slot.
  always_comb begin
    state_d      = state_q;
    px_d         = px_q;
    py_d         = py_q;
    sx_d         = sx_q;
    sy_d         = sy_q;
    out_valid_d  = out_valid_q && !out_ready;
    out_win_d    = out_win_q;
    frame_done_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // With padding the top pad rows need no input, so start at once.
        if (in_valid || HAS_PAD) state_d = S_RUN;
      end
      S_RUN: begin
        if (step) begin
          if (emit_pos) begin
            out_valid_d = 1'b1;
            out_win_d   = win_flat;
          end
          if (px_q == X_LAST) begin
            px_d = '0;
            sx_d = '0;
            if (py_q == Y_LAST) begin
              py_d    = '0;
              sy_d    = '0;
              state_d = S_DRAIN;
            end else begin
              py_d = py_q + YW'(1);
              sy_d = (py_q < Y_KM1 || sy_q == S_LAST) ? '0 : sy_q + SW'(1);
            end
          end else begin
            px_d = px_q + XW'(1);
            sx_d = (px_q < X_KM1 || sx_q == S_LAST) ? '0 : sx_q + SW'(1);
          end
        end
      end
      S_DRAIN: begin
        if (!out_valid_q || out_ready) begin
          frame_done_d = 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (clear) begin
      state_d      = S_IDLE;
      px_d         = '0;
      py_d         = '0;
      sx_d         = '0;
      sy_d         = '0;
      out_valid_d  = 1'b0;
      frame_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      px_q         <= '0;
      py_q         <= '0;
      sx_q         <= '0;
      sy_q         <= '0;
      out_valid_q  <= 1'b0;
      out_win_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      px_q         <= px_d;
      py_q         <= py_d;
      sx_q         <= sx_d;
      sy_q         <= sy_d;
      out_valid_q  <= out_valid_d;
      out_win_q    <= out_win_d;
      frame_done_q <= frame_done_d;
    end
  end

  // NOTE: line memories and the window register carry no reset. A window is
  // emitted only once py >= K-1 and px >= K-1, by which point every entry it
  // reads was rewritten during the current frame, so stale contents never escape.
  always_ff @(posedge clk) begin
    if (step) begin
      for (int r = 0; r < KER_SIZE - 1; r++) lm_q[r][px_q[AW-1:0]] <= new_col[r+1];
    end
    win_q <= win_d;
  end

  assign out_valid  = out_valid_q;
  assign out_win    = out_win_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_window_stream_gen.sv
// ---------------------------------------------------------------------------
// tb_window_stream_gen
//   Four instances of window_stream_gen on a 4x4 image with different kernel,
//   stride, pad and channel settings. Expected windows come from a direct
//   coordinate model: window (ox,oy) lane (r,k) reads image pixel
//   (ox*S+k-P, oy*S+r-P), or zero outside the image.
// ---------------------------------------------------------------------------
module tb_window_stream_gen;

  localparam int WMAX = 400;
  localparam int DMAX = 24;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic            in_valid  [4];
  logic            out_ready [4];
  logic            clear     [4];
  logic            in_ready  [4];
  logic            out_valid [4];
  logic            frame_done[4];
  logic [DMAX-1:0] in_data   [4];
  logic [WMAX-1:0] win_bus   [4];

  logic [215:0] w0;
  logic [215:0] w1;
  logic [95:0]  w2;
  logic [399:0] w3;
  assign win_bus[0] = WMAX'(w0);
  assign win_bus[1] = WMAX'(w1);
  assign win_bus[2] = WMAX'(w2);
  assign win_bus[3] = w3;

  window_stream_gen #(.KER_SIZE(3), .BITWIDTH(8), .NFMAPS(3), .IMG_W(4), .IMG_H(4),
                      .STRIDE(1), .PAD(1)) d0 (
    .clk(clk), .rstn(rstn), .clear(clear[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0][23:0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_win(w0), .frame_done(frame_done[0]));

  window_stream_gen #(.KER_SIZE(3), .BITWIDTH(8), .NFMAPS(3), .IMG_W(4), .IMG_H(4),
                      .STRIDE(2), .PAD(1)) d1 (
    .clk(clk), .rstn(rstn), .clear(clear[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1][23:0]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_win(w1), .frame_done(frame_done[1]));

  window_stream_gen #(.KER_SIZE(2), .BITWIDTH(8), .NFMAPS(3), .IMG_W(4), .IMG_H(4),
                      .STRIDE(1), .PAD(0)) d2 (
    .clk(clk), .rstn(rstn), .clear(clear[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2][23:0]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_win(w2), .frame_done(frame_done[2]));

  window_stream_gen #(.KER_SIZE(5), .BITWIDTH(8), .NFMAPS(2), .IMG_W(4), .IMG_H(4),
                      .STRIDE(1), .PAD(2)) d3 (
    .clk(clk), .rstn(rstn), .clear(clear[3]), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
    .in_data(in_data[3][15:0]), .out_valid(out_valid[3]), .out_ready(out_ready[3]),
    .out_win(w3), .frame_done(frame_done[3]));

  int vectors    = 0;
  int miscompares = 0;
  int img [4][4][3];
  logic [WMAX-1:0] cap [$];

  function automatic logic [WMAX-1:0] model_win(int k_sz, int pad, int s, int nf, int ox, int oy);
    logic [WMAX-1:0] w;
    int x, y, v;
    w = '0;
    for (int c = 0; c < nf; c++)
      for (int r = 0; r < k_sz; r++)
        for (int k = 0; k < k_sz; k++) begin
          y = oy * s + r - pad;
          x = ox * s + k - pad;
          v = (x >= 0 && x < 4 && y >= 0 && y < 4) ? img[y][x][c] : 0;
          w[(c*k_sz*k_sz + r*k_sz + k)*8 +: 8] = 8'(v);
        end
    return w;
  endfunction

  function automatic int lane(logic [WMAX-1:0] w, int k_sz, int c, int idx);
    return int'(w[(c*k_sz*k_sz + idx)*8 +: 8]);
  endfunction

  // mode 0: ch0 = 1..16 raster; mode 1: ch1 = ch0 + 100; mode 2: all random
  task automatic fill_img(input int mode);
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++) begin
        img[y][x][0] = (mode == 0) ? y*4 + x + 1 : int'($urandom_range(150, 1));
        img[y][x][1] = (mode == 1) ? img[y][x][0] + 100 : int'($urandom_range(255));
        img[y][x][2] = int'($urandom_range(255));
      end
  endtask

  // Streams one frame into DUT d and checks every window, timing and frame_done.
  task automatic run_frame(input int d, input int k_sz, input int pad, input int s,
                           input int nf, input int vprob, input int rprob,
                           input int stall_at, input int abort_after, input bit no_bubble);
    logic [WMAX-1:0] exp_q [$];
    logic [WMAX-1:0] held;
    int ow, oh, beat, nwin, done_cnt, cyc, stall_left, bubbles, post, px, py;
    bit exp_valid_next, stall_done;
    ow = (4 + 2*pad - k_sz) / s + 1;
    oh = ow;
    for (int oy = 0; oy < oh; oy++)
      for (int ox = 0; ox < ow; ox++) exp_q.push_back(model_win(k_sz, pad, s, nf, ox, oy));
    held = '0;
    beat = 0; nwin = 0; done_cnt = 0; cyc = 0; stall_left = 0; bubbles = 0; post = 0;
    exp_valid_next = 1'b0; stall_done = 1'b0;
    while (cyc < 3000 && post < 3) begin
      @(negedge clk);
      cyc++;
      in_valid[d] = (beat < 16) && ($urandom_range(99) < vprob);
      in_data[d]  = '0;
      if (beat < 16)
        for (int c = 0; c < nf; c++) in_data[d][c*8 +: 8] = 8'(img[beat/4][beat%4][c]);
      if (!stall_done && stall_at >= 0 && out_valid[d] && nwin == stall_at) begin
        stall_left = 10;
        stall_done = 1'b1;
        held       = win_bus[d];
      end
      out_ready[d] = (stall_left > 0) ? 1'b0 : ($urandom_range(99) < rprob);
      #1;
      if (exp_valid_next) begin
        vectors++;
        if (out_valid[d] !== 1'b1) begin
          miscompares++;
          $display("FAIL latency dut%0d beat %0d: out_valid=%b, required 1", d, beat, out_valid[d]);
        end
        exp_valid_next = 1'b0;
      end
      if (stall_left > 0) begin
        vectors++;
        if (out_valid[d] !== 1'b1 || win_bus[d] !== held) begin
          miscompares++;
          $display("FAIL stall_hold dut%0d: valid=%b win=%h, required valid=1 win=%h",
                   d, out_valid[d], win_bus[d], held);
        end
        if (stall_left == 1) begin
          vectors++;
          if (in_ready[d] !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_in_ready dut%0d: in_ready=%b, required 0", d, in_ready[d]);
          end
        end
        stall_left--;
      end
      if (frame_done[d]) begin
        done_cnt++;
        vectors++;
        if (nwin != exp_q.size()) begin
          miscompares++;
          $display("FAIL frame_done_early dut%0d: windows=%0d, required %0d", d, nwin, exp_q.size());
        end
      end
      if (done_cnt == 0 && beat >= 16) begin
        vectors++;
        if (in_ready[d] !== 1'b0) begin
          miscompares++;
          $display("FAIL pad_in_ready dut%0d: in_ready=%b after last beat, required 0", d, in_ready[d]);
        end
      end
      if (no_bubble && beat > 0 && beat < 16 && in_valid[d] && !in_ready[d]) bubbles++;
      if (out_valid[d] && out_ready[d]) begin
        vectors++;
        if (nwin >= exp_q.size()) begin
          miscompares++;
          $display("FAIL extra_window dut%0d: window %0d, required at most %0d", d, nwin, exp_q.size());
        end else if (win_bus[d] !== exp_q[nwin]) begin
          miscompares++;
          $display("FAIL window dut%0d #%0d: got %h, required %h", d, nwin, win_bus[d], exp_q[nwin]);
        end
        cap.push_back(win_bus[d]);
        nwin++;
      end
      if (in_valid[d] && in_ready[d]) begin
        px = beat % 4 + pad;
        py = beat / 4 + pad;
        if (px >= k_sz - 1 && py >= k_sz - 1 && (px - k_sz + 1) % s == 0 && (py - k_sz + 1) % s == 0)
          exp_valid_next = 1'b1;
        beat++;
        if (abort_after >= 0 && beat >= abort_after) return;
      end
      if (done_cnt > 0) post++;
    end
    in_valid[d]  = 1'b0;
    out_ready[d] = 1'b0;
    vectors++;
    if (nwin != exp_q.size()) begin
      miscompares++;
      $display("FAIL window_count dut%0d: got %0d, required %0d", d, nwin, exp_q.size());
    end
    vectors++;
    if (done_cnt != 1) begin
      miscompares++;
      $display("FAIL frame_done_count dut%0d: got %0d pulses, required 1", d, done_cnt);
    end
    if (no_bubble) begin
      vectors++;
      if (bubbles != 0) begin
        miscompares++;
        $display("FAIL bubbles dut%0d: got %0d stalled input cycles, required 0", d, bubbles);
      end
    end
  endtask

  task automatic check_lit(input string name, input int idx, input int k_sz, input int lit[]);
    vectors++;
    if (cap.size() <= idx) begin
      miscompares++;
      $display("FAIL %s: only %0d windows captured, required index %0d", name, cap.size(), idx);
    end else begin
      for (int i = 0; i < k_sz*k_sz; i++) begin
        if (lane(cap[idx], k_sz, 0, i) != lit[i]) begin
          miscompares++;
          $display("FAIL %s lane %0d: got %0d, required %0d", name, i, lane(cap[idx], k_sz, 0, i), lit[i]);
          break;
        end
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    for (int d = 0; d < 4; d++) begin
      vectors++;
      if (out_valid[d] !== 1'b0 || in_ready[d] !== 1'b0 || frame_done[d] !== 1'b0 || win_bus[d] !== '0) begin
        miscompares++;
        $display("FAIL reset dut%0d: valid=%b ready=%b done=%b win=%h, required all 0",
                 d, out_valid[d], in_ready[d], frame_done[d], win_bus[d]);
      end
    end
  endtask

  task automatic test_pad_k3();
    int first[] = '{0, 0, 0, 0, 1, 2, 0, 5, 6};
    int last[]  = '{11, 12, 0, 15, 16, 0, 0, 0, 0};
    fill_img(0);
    cap.delete();
    run_frame(0, 3, 1, 1, 3, 100, 100, -1, -1, 1'b0);
    check_lit("k3_first", 0, 3, first);
    check_lit("k3_last", 15, 3, last);
  endtask

  task automatic test_stride2();
    int second[] = '{0, 0, 0, 2, 3, 4, 6, 7, 8};
    int third[]  = '{0, 5, 6, 0, 9, 10, 0, 13, 14};
    fill_img(0);
    cap.delete();
    run_frame(1, 3, 1, 2, 3, 100, 100, -1, -1, 1'b0);
    check_lit("s2_second", 1, 3, second);
    check_lit("s2_third", 2, 3, third);
  endtask

  task automatic test_k2_nopad();
    int first[] = '{1, 2, 5, 6};
    fill_img(0);
    cap.delete();
    run_frame(2, 2, 0, 1, 3, 100, 100, -1, -1, 1'b1);
    check_lit("k2_first", 0, 2, first);
  endtask

  task automatic test_backpressure();
    fill_img(2);
    cap.delete();
    run_frame(0, 3, 1, 1, 3, 100, 100, 4, -1, 1'b0);
  endtask

  task automatic test_k5_two_ch();
    int a, b;
    bit ok;
    fill_img(1);
    cap.delete();
    run_frame(3, 5, 2, 1, 2, 100, 100, -1, -1, 1'b0);
    foreach (cap[w]) begin
      ok = 1'b1;
      for (int i = 0; i < 25; i++) begin
        a = lane(cap[w], 5, 0, i);
        b = lane(cap[w], 5, 1, i);
        if (!((a == 0 && b == 0) || b == a + 100)) ok = 1'b0;
      end
      vectors++;
      if (!ok) begin
        miscompares++;
        $display("FAIL ch1_offset window %0d: ch1 lanes not ch0+100, got %h", w, cap[w]);
      end
    end
  endtask

  task automatic test_random_flow();
    fill_img(2);
    run_frame(0, 3, 1, 1, 3, 60, 50, -1, -1, 1'b0);
    run_frame(3, 5, 2, 1, 2, 70, 40, -1, -1, 1'b0);
    run_frame(1, 3, 1, 2, 3, 50, 60, -1, -1, 1'b0);
    run_frame(2, 2, 0, 1, 3, 40, 70, -1, -1, 1'b0);
  endtask

  task automatic test_clear();
    int first[] = '{0, 0, 0, 0, 1, 2, 0, 5, 6};
    fill_img(0);
    run_frame(0, 3, 1, 1, 3, 100, 70, -1, int'($urandom_range(12, 7)), 1'b0);
    @(negedge clk);
    clear[0] = 1'b1; in_valid[0] = 1'b0; out_ready[0] = 1'b0;
    @(negedge clk);
    clear[0] = 1'b0;
    #1;
    vectors++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL clear dut0: valid=%b ready=%b, required 0 0", out_valid[0], in_ready[0]);
    end
    cap.delete();
    run_frame(0, 3, 1, 1, 3, 100, 100, -1, -1, 1'b0);
    check_lit("clear_first", 0, 3, first);
  endtask

  task automatic test_rstn_mid();
    int first[] = '{0, 0, 0, 0, 1, 2, 0, 5, 6};
    fill_img(0);
    run_frame(0, 3, 1, 1, 3, 100, 70, -1, int'($urandom_range(12, 7)), 1'b0);
    @(negedge clk);
    rstn = 1'b0; in_valid[0] = 1'b0; out_ready[0] = 1'b0;
    #1;
    vectors++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b0 || frame_done[0] !== 1'b0 || win_bus[0] !== '0) begin
      miscompares++;
      $display("FAIL rstn_mid dut0: valid=%b ready=%b done=%b win=%h, required all 0",
               out_valid[0], in_ready[0], frame_done[0], win_bus[0]);
    end
    @(negedge clk);
    rstn = 1'b1;
    cap.delete();
    run_frame(0, 3, 1, 1, 3, 100, 100, -1, -1, 1'b0);
    check_lit("rstn_first", 0, 3, first);
  endtask

  initial begin
    for (int d = 0; d < 4; d++) begin
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b0;
      clear[d]     = 1'b0;
      in_data[d]   = '0;
    end
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rstn = 1'b1;
    test_pad_k3();
    test_stride2();
    test_k2_nopad();
    test_backpressure();
    test_k5_two_ch();
    test_random_flow();
    test_clear();
    test_rstn_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
